// File: rtl/s_chunk_packer_pkg.sv
// ---------------------------------------------------------------------------
// s_chunk_packer_pkg
// Shared definitions for the S-sequence chunk packer:
//   - default PE-array geometry (bases per chunk and its log2)
//   - base code encoding (A/C/G/T = 0..3)
//   - control FSM state encoding and a helper that classifies the next state
// ---------------------------------------------------------------------------
package s_chunk_packer_pkg;

   localparam int PE_ARRAY_SIZE     = 64;
   localparam int PE_ARRAY_SIZE_LOG = 6;

   typedef enum logic [1:0] {
      BASE_A = 2'd0,
      BASE_C = 2'd1,
      BASE_G = 2'd2,
      BASE_T = 2'd3
   } base_e;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,   // nothing buffered, no request outstanding
      ST_FILLING   = 2'd1,   // FILL partially written and/or READY holds a chunk
      ST_STALL     = 2'd2,   // FILL complete and READY occupied: input blocked
      ST_WAIT_DATA = 2'd3    // request outstanding, READY empty
   } pack_state_e;

   // Classify the state the packer will be in after the current edge.
   // Pending and STALL are mutually exclusive: pending implies READY empty.
   function automatic pack_state_e pack_state_f(
      input logic i_pending,
      input logic i_fill_full,
      input logic i_ready_full,
      input logic i_fill_busy
   );
      pack_state_e v_state;
      if (i_pending) begin
         v_state = ST_WAIT_DATA;
      end else if (i_fill_full && i_ready_full) begin
         v_state = ST_STALL;
      end else if (i_ready_full || i_fill_busy) begin
         v_state = ST_FILLING;
      end else begin
         v_state = ST_IDLE;
      end
      return v_state;
   endfunction

endpackage

// File: rtl/s_chunk_packer_slot.sv
// ---------------------------------------------------------------------------
// s_chunk_slot
// One chunk buffer of the packer: 2*PE_N data bits, a base count and a full
// flag. Used twice by the top: once as the FILL slot (written base by base)
// and once as the READY slot (loaded whole from its peer).
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   i_clear          synchronous flush (highest priority)
//   i_load_en        load i_load_data/i_load_count and mark full
//   i_release        empty the slot (data and count zeroed)
//   i_wr_en          write i_wr_base at base index i_wr_idx
//   i_wr_complete    with i_wr_en: mark full with count i_wr_count
//   o_data/o_count/o_full   current slot contents
// Priority per edge: clear > load > release > write. Zeroing on release keeps
// the unused upper bases of a later partial chunk at zero.
// ---------------------------------------------------------------------------
module s_chunk_slot
   import s_chunk_packer_pkg::*;
#(
   parameter int PE_N     = PE_ARRAY_SIZE,
   parameter int PE_N_LOG = PE_ARRAY_SIZE_LOG
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  i_clear,
   input  logic                  i_load_en,
   input  logic [2*PE_N-1:0]     i_load_data,
   input  logic [PE_N_LOG:0]     i_load_count,
   input  logic                  i_release,
   input  logic                  i_wr_en,
   input  logic [PE_N_LOG-1:0]   i_wr_idx,
   input  logic [1:0]            i_wr_base,
   input  logic                  i_wr_complete,
   input  logic [PE_N_LOG:0]     i_wr_count,
   output logic [2*PE_N-1:0]     o_data,
   output logic [PE_N_LOG:0]     o_count,
   output logic                  o_full
);

   logic [2*PE_N-1:0] r_data;
   logic [PE_N_LOG:0] r_count;
   logic              r_full;

   // Slot storage: flush, whole-chunk load, release, or single-base write.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_data  <= {(2*PE_N){1'b0}};
         r_count <= {(PE_N_LOG+1){1'b0}};
         r_full  <= 1'b0;
      end else if (i_clear) begin
         r_data  <= {(2*PE_N){1'b0}};
         r_count <= {(PE_N_LOG+1){1'b0}};
         r_full  <= 1'b0;
      end else if (i_load_en) begin
         r_data  <= i_load_data;
         r_count <= i_load_count;
         r_full  <= 1'b1;
      end else if (i_release) begin
         r_data  <= {(2*PE_N){1'b0}};
         r_count <= {(PE_N_LOG+1){1'b0}};
         r_full  <= 1'b0;
      end else if (i_wr_en) begin
         r_data[{i_wr_idx, 1'b0} +: 2] <= i_wr_base;
         if (i_wr_complete) begin
            r_full  <= 1'b1;
            r_count <= i_wr_count;
         end
      end
   end

   assign o_data  = r_data;
   assign o_count = r_count;
   assign o_full  = r_full;

endmodule

// File: rtl/s_chunk_packer.sv
// ---------------------------------------------------------------------------
// s_chunk_packer
// Packs serially arriving 2-bit bases into PE_N-base chunks using a FILL and a
// READY slot, and returns one chunk per one-cycle request on o_s/o_s_valid.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   i_clear                    synchronous flush of both slots and pending request
//   i_base_valid/i_base/i_base_last   base stream (accepted with o_base_ready)
//   o_base_ready               low only while FILL is complete and READY occupied
//   i_request_s                one-cycle request for the next chunk
//   o_s                        packed chunk, base k at bits [2k+1:2k]
//   o_s_valid                  base count of o_s for one cycle, 0 otherwise
// ---------------------------------------------------------------------------
module s_chunk_packer
   import s_chunk_packer_pkg::*;
#(
   parameter int PE_N     = PE_ARRAY_SIZE,
   parameter int PE_N_LOG = PE_ARRAY_SIZE_LOG
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  i_clear,
   input  logic                  i_base_valid,
   input  logic [1:0]            i_base,
   input  logic                  i_base_last,
   output logic                  o_base_ready,
   input  logic                  i_request_s,
   output logic [2*PE_N-1:0]     o_s,
   output logic [PE_N_LOG:0]     o_s_valid
);

   logic [2*PE_N-1:0]   w_fill_data;
   logic [2*PE_N-1:0]   w_ready_data;
   logic [2*PE_N-1:0]   w_merged;
   logic [2*PE_N-1:0]   w_load_data;
   logic [PE_N_LOG:0]   w_fill_count;
   logic [PE_N_LOG:0]   w_ready_count;
   logic [PE_N_LOG:0]   w_wr_count;
   logic [PE_N_LOG:0]   w_load_count;
   logic                w_fill_full;
   logic                w_ready_full;
   logic                w_accept;
   logic                w_req;
   logic                w_idx_last;
   logic                w_complete;
   logic                w_serve;
   logic                w_move;
   logic                w_pending_next;
   logic                w_fill_full_next;
   logic                w_ready_full_next;
   logic [PE_N_LOG-1:0] w_idx_next;
   pack_state_e         w_state_next;

   pack_state_e         r_state;
   logic                r_pending;
   logic [PE_N_LOG-1:0] r_idx;
   logic [2*PE_N-1:0]   r_s;
   logic [PE_N_LOG:0]   r_s_valid;

   assign o_base_ready = (r_state != ST_STALL);
   assign o_s          = r_s;
   assign o_s_valid    = r_s_valid;

   // Next-step control: base acceptance, chunk completion, serving and the
   // FILL->READY transfer, plus the resulting state classification.
   always_comb begin
      w_accept   = i_base_valid & o_base_ready & ~i_clear;
      w_req      = i_request_s & ~i_clear;
      w_idx_last = (r_idx == PE_N_LOG'(PE_N - 1));
      w_complete = w_accept & (i_base_last | w_idx_last);
      w_wr_count = {1'b0, r_idx} + (PE_N_LOG+1)'(1'b1);

      // FILL contents including the base written this edge, so a chunk can
      // move to READY on the same edge it completes.
      w_merged = w_fill_data;
      w_merged[{r_idx, 1'b0} +: 2] = i_base;

      w_serve = w_ready_full & (w_req | r_pending) & ~i_clear;
      // READY being drained this edge counts as free for the transfer.
      w_move  = ~i_clear & (w_fill_full | w_complete) & (~w_ready_full | w_serve);

      if (w_fill_full) begin
         w_load_data  = w_fill_data;
         w_load_count = w_fill_count;
      end else begin
         w_load_data  = w_merged;
         w_load_count = w_wr_count;
      end

      if (i_clear) begin
         w_idx_next = {PE_N_LOG{1'b0}};
      end else if (w_accept) begin
         if (w_complete) begin
            w_idx_next = {PE_N_LOG{1'b0}};
         end else begin
            w_idx_next = r_idx + PE_N_LOG'(1'b1);
         end
      end else begin
         w_idx_next = r_idx;
      end

      w_pending_next    = (r_pending | w_req) & ~w_serve & ~i_clear;
      w_fill_full_next  = ~i_clear & ~w_move & (w_fill_full | w_complete);
      w_ready_full_next = ~i_clear & (w_move | (w_ready_full & ~w_serve));
      w_state_next      = pack_state_f(w_pending_next, w_fill_full_next,
                                       w_ready_full_next, (w_idx_next != {PE_N_LOG{1'b0}}));
   end

   // Control FSM with registered response outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= ST_IDLE;
         r_pending <= 1'b0;
         r_idx     <= {PE_N_LOG{1'b0}};
         r_s       <= {(2*PE_N){1'b0}};
         r_s_valid <= {(PE_N_LOG+1){1'b0}};
      end else if (i_clear) begin
         r_state   <= ST_IDLE;
         r_pending <= 1'b0;
         r_idx     <= {PE_N_LOG{1'b0}};
         r_s       <= {(2*PE_N){1'b0}};
         r_s_valid <= {(PE_N_LOG+1){1'b0}};
      end else begin
         r_state   <= w_state_next;
         r_pending <= w_pending_next;
         r_idx     <= w_idx_next;
         if (w_serve) begin
            r_s       <= w_ready_data;
            r_s_valid <= w_ready_count;
         end else begin
            r_s       <= {(2*PE_N){1'b0}};
            r_s_valid <= {(PE_N_LOG+1){1'b0}};
         end
      end
   end

   s_chunk_slot #(
      .PE_N     (PE_N),
      .PE_N_LOG (PE_N_LOG)
   ) u_fill_slot (
      .clk           (clk),
      .rst_n         (rst_n),
      .i_clear       (i_clear),
      .i_load_en     (1'b0),
      .i_load_data   ({(2*PE_N){1'b0}}),
      .i_load_count  ({(PE_N_LOG+1){1'b0}}),
      .i_release     (w_move),
      .i_wr_en       (w_accept),
      .i_wr_idx      (r_idx),
      .i_wr_base     (i_base),
      .i_wr_complete (w_complete),
      .i_wr_count    (w_wr_count),
      .o_data        (w_fill_data),
      .o_count       (w_fill_count),
      .o_full        (w_fill_full)
   );

   s_chunk_slot #(
      .PE_N     (PE_N),
      .PE_N_LOG (PE_N_LOG)
   ) u_ready_slot (
      .clk           (clk),
      .rst_n         (rst_n),
      .i_clear       (i_clear),
      .i_load_en     (w_move),
      .i_load_data   (w_load_data),
      .i_load_count  (w_load_count),
      .i_release     (w_serve),
      .i_wr_en       (1'b0),
      .i_wr_idx      ({PE_N_LOG{1'b0}}),
      .i_wr_base     (2'b00),
      .i_wr_complete (1'b0),
      .i_wr_count    ({(PE_N_LOG+1){1'b0}}),
      .o_data        (w_ready_data),
      .o_count       (w_ready_count),
      .o_full        (w_ready_full)
   );

endmodule

// File: tb/tb_s_chunk_packer.sv
// ---------------------------------------------------------------------------
// tb_s_chunk_packer
// Directed and randomized bench for s_chunk_packer with PE_N = 4. Expected
// chunks are queued as they are fed; every response is popped and compared.
// ---------------------------------------------------------------------------
module tb_s_chunk_packer;
   import s_chunk_packer_pkg::*;

   localparam int PE_N     = 4;
   localparam int PE_N_LOG = 2;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       i_clear;
   logic       i_base_valid;
   logic [1:0] i_base;
   logic       i_base_last;
   logic       o_base_ready;
   logic       i_request_s;
   logic [7:0] o_s;
   logic [2:0] o_s_valid;

   int          n_vec = 0;
   int          n_err = 0;
   logic [10:0] exp_q[$];
   logic [10:0] mon_exp;

   always #5 clk = ~clk;

   s_chunk_packer #(
      .PE_N     (PE_N),
      .PE_N_LOG (PE_N_LOG)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .i_clear      (i_clear),
      .i_base_valid (i_base_valid),
      .i_base       (i_base),
      .i_base_last  (i_base_last),
      .o_base_ready (o_base_ready),
      .i_request_s  (i_request_s),
      .o_s          (o_s),
      .o_s_valid    (o_s_valid)
   );

   task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Response monitor: every non-zero count must match the next queued chunk.
   always @(negedge clk) begin
      if (rst_n && (o_s_valid != 3'd0)) begin
         if (exp_q.size() == 0) begin
            chk_eq("unexpected_resp", {21'b0, o_s_valid, o_s}, 32'd0);
         end else begin
            mon_exp = exp_q.pop_front();
            chk_eq("resp", {21'b0, o_s_valid, o_s}, {21'b0, mon_exp});
         end
      end
   end

   task automatic send_base(input logic [1:0] b, input logic last);
      int guard = 0;
      i_base_valid = 1'b1;
      i_base       = b;
      i_base_last  = last;
      while (!o_base_ready && guard < 50) begin
         tick();
         guard++;
      end
      if (guard >= 50) chk_eq("base_ready_timeout", {31'b0, o_base_ready}, 32'd1);
      tick();
      i_base_valid = 1'b0;
      i_base_last  = 1'b0;
   endtask

   // Feeds len bases from data (base k at bits 2k+1:2k) and queues the chunk.
   task automatic send_chunk(input int len, input logic [7:0] data, input logic use_last);
      logic [7:0] m;
      logic [7:0] d;
      m = 8'hFF >> (8 - 2 * len);
      d = data & m;
      for (int k = 0; k < len; k++) begin
         send_base(d[2*k +: 2], use_last && (k == len - 1));
      end
      exp_q.push_back({3'(len), d});
   endtask

   // Request while READY holds a chunk: one-cycle response, then idle.
   task automatic req_check(input string tag, input logic [2:0] cnt, input logic [7:0] data);
      i_request_s = 1'b1;
      tick();
      i_request_s = 1'b0;
      chk_eq({tag, "_cnt"}, {29'b0, o_s_valid}, {29'b0, cnt});
      chk_eq({tag, "_data"}, {24'b0, o_s}, {24'b0, data});
      tick();
      chk_eq({tag, "_cnt_after"}, {29'b0, o_s_valid}, 32'd0);
      chk_eq({tag, "_data_after"}, {24'b0, o_s}, 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] rnd;
      int         len;
      rst_n        = 1'b0;
      i_clear      = 1'b0;
      i_base_valid = 1'b0;
      i_base       = 2'd0;
      i_base_last  = 1'b0;
      i_request_s  = 1'b0;
      tick();
      tick();
      chk_eq("rst_ready", {31'b0, o_base_ready}, 32'd1);
      chk_eq("rst_valid", {29'b0, o_s_valid}, 32'd0);
      chk_eq("rst_data", {24'b0, o_s}, 32'd0);
      rst_n = 1'b1;
      tick();

      // Full chunk 0,1,2,3
      send_chunk(4, 8'hE4, 1'b0);
      req_check("full", 3'd4, 8'hE4);

      // Partial chunk 3,2(last): upper bits zero
      send_chunk(2, 8'hFB, 1'b1);
      req_check("partial", 3'd2, 8'h0B);

      // Two chunks with no request: input stalls until READY drains
      send_chunk(4, 8'hE4, 1'b0);
      send_chunk(4, 8'h1B, 1'b0);
      chk_eq("stall_ready", {31'b0, o_base_ready}, 32'd0);
      i_request_s = 1'b1;
      tick();
      i_request_s = 1'b0;
      chk_eq("stall_cnt", {29'b0, o_s_valid}, 32'd4);
      chk_eq("stall_data", {24'b0, o_s}, 32'hE4);
      chk_eq("stall_ready_after", {31'b0, o_base_ready}, 32'd1);
      tick();
      req_check("stall_second", 3'd4, 8'h1B);

      // Request before data; second request while pending is ignored
      i_request_s = 1'b1;
      tick();
      chk_eq("pend_idle", {29'b0, o_s_valid}, 32'd0);
      tick();
      i_request_s = 1'b0;
      send_chunk(4, 8'h6C, 1'b0);
      chk_eq("pend_not_yet", {29'b0, o_s_valid}, 32'd0);
      tick();
      chk_eq("pend_cnt", {29'b0, o_s_valid}, 32'd4);
      chk_eq("pend_data", {24'b0, o_s}, 32'h6C);
      for (int i = 0; i < 4; i++) tick();
      chk_eq("pend_no_extra", {29'b0, o_s_valid}, 32'd0);

      // Clear with both slots full; base and request in the clear cycle dropped
      send_chunk(4, 8'h55, 1'b0);
      send_chunk(4, 8'hAA, 1'b0);
      chk_eq("clr_stalled", {31'b0, o_base_ready}, 32'd0);
      i_clear      = 1'b1;
      i_request_s  = 1'b1;
      i_base_valid = 1'b1;
      i_base       = 2'd3;
      tick();
      i_clear      = 1'b0;
      i_request_s  = 1'b0;
      i_base_valid = 1'b0;
      exp_q.delete();
      chk_eq("clr_valid", {29'b0, o_s_valid}, 32'd0);
      chk_eq("clr_ready", {31'b0, o_base_ready}, 32'd1);
      tick();
      chk_eq("clr_valid2", {29'b0, o_s_valid}, 32'd0);

      // Clear drops a pending request
      i_request_s = 1'b1;
      tick();
      i_request_s = 1'b0;
      i_clear     = 1'b1;
      tick();
      i_clear = 1'b0;
      send_chunk(4, 8'h27, 1'b0);
      tick();
      chk_eq("clr_pend_dropped", {29'b0, o_s_valid}, 32'd0);
      tick();
      req_check("clr_restart", 3'd4, 8'h27);

      // Reset mid-fill
      send_base(2'd3, 1'b0);
      send_base(2'd3, 1'b0);
      rst_n = 1'b0;
      #2;
      chk_eq("midrst_ready", {31'b0, o_base_ready}, 32'd1);
      chk_eq("midrst_valid", {29'b0, o_s_valid}, 32'd0);
      tick();
      rst_n = 1'b1;
      tick();
      send_chunk(4, 8'hB1, 1'b0);
      req_check("midrst_chunk", 3'd4, 8'hB1);

      // Last on index PE_N-1, then a one-base sequence
      send_chunk(4, 8'hE4, 1'b1);
      send_chunk(1, 8'h01, 1'b1);
      chk_eq("last_stall", {31'b0, o_base_ready}, 32'd0);
      req_check("last_full", 3'd4, 8'hE4);
      req_check("last_single", 3'd1, 8'h01);

      // Random chunk lengths and contents
      for (int n = 0; n < 8; n++) begin
         len = $urandom_range(1, 4);
         rnd = 8'($urandom);
         send_chunk(len, rnd, 1'b1);
         i_request_s = 1'b1;
         tick();
         i_request_s = 1'b0;
         tick();
      end
      for (int i = 0; i < 4; i++) tick();
      chk_eq("queue_drained", exp_q.size(), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
